// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 scancode constants, receiver state type and scancode-to-ASCII map
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam logic [7:0] ASCII_ENTER = 8'h0D;
  localparam logic [7:0] ASCII_BKSP  = 8'h08;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Returns {valid, ascii}; shift only matters for codes that have a shifted glyph.
  function automatic logic [8:0] sc_to_ascii(input logic [7:0] code, input logic shift);
    logic [7:0] c;
    logic [7:0] s;
    c = 8'h00;
    s = 8'h00;
    case (code)
      8'h1C: c = "a";  8'h32: c = "b";  8'h21: c = "c";  8'h23: c = "d";
      8'h24: c = "e";  8'h2B: c = "f";  8'h34: c = "g";  8'h33: c = "h";
      8'h43: c = "i";  8'h3B: c = "j";  8'h42: c = "k";  8'h4B: c = "l";
      8'h3A: c = "m";  8'h31: c = "n";  8'h44: c = "o";  8'h4D: c = "p";
      8'h15: c = "q";  8'h2D: c = "r";  8'h1B: c = "s";  8'h2C: c = "t";
      8'h3C: c = "u";  8'h2A: c = "v";  8'h1D: c = "w";  8'h22: c = "x";
      8'h35: c = "y";  8'h1A: c = "z";
      8'h45: begin c = "0"; s = ")"; end
      8'h16: begin c = "1"; s = "!"; end
      8'h1E: begin c = "2"; s = "@"; end
      8'h26: begin c = "3"; s = "#"; end
      8'h25: begin c = "4"; s = "$"; end
      8'h2E: begin c = "5"; s = "%"; end
      8'h36: begin c = "6"; s = "^"; end
      8'h3D: begin c = "7"; s = "&"; end
      8'h3E: begin c = "8"; s = "*"; end
      8'h46: begin c = "9"; s = "("; end
      8'h41: begin c = ","; s = "<"; end
      8'h49: begin c = "."; s = ">"; end
      8'h29: c = " ";
      SC_ENTER: c = ASCII_ENTER;
      SC_BKSP:  c = ASCII_BKSP;
      default:  c = 8'h00;
    endcase
    if (c >= "a" && c <= "z") s = c - 8'h20;
    if (shift && s != 8'h00) c = s;
    return {c != 8'h00, c};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 pin synchronizer, falling-edge detect, 11-bit frame FSM with timeout
module ps2_rx import ps2_pkg::*; #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       byte_valid,
  output logic [7:0] data_byte,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   sdata;
  rx_state_t              state;
  logic [2:0]             bit_cnt;
  logic                   par_ok;
  logic [TW-1:0]          timer;

  assign fall  = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign sdata = data_sync[SYNC_STAGES-1];

  // Idle-high reset values so a quiet bus never looks like an edge after release.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      par_ok     <= 1'b0;
      timer      <= '0;
      data_byte  <= '0;
      byte_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      err        <= 1'b0;
      if (state == RX_IDLE || fall) timer <= '0;
      else                          timer <= timer + TW'(1);

      if (state != RX_IDLE && !fall && timer == T_LAST) begin
        err   <= 1'b1;
        state <= RX_IDLE;
      end else if (fall) begin
        case (state)
          RX_IDLE: begin
            if (sdata) err <= 1'b1;
            else begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            data_byte <= {sdata, data_byte[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            // Parity verdict is held until the stop bit so all errors share one latency.
            par_ok <= ^{data_byte, sdata};
            state  <= RX_STOP;
          end
          RX_STOP: begin
            state <= RX_IDLE;
            if (sdata && par_ok) byte_valid <= 1'b1;
            else                 err        <= 1'b1;
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_line_buffer.sv
// rtl/ps2_line_buffer.sv - PS/2 make/break decoder, bounded line editor and line valid/ready hold
// Optional shift-key handling is enabled with the macro PS2_SHIFT_EN.
module ps2_line_buffer import ps2_pkg::*; #(
  parameter int MAX_LEN        = 32,
  parameter int CHAR_W         = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           ps2_clk_in,
  input  logic                           ps2_data_in,
  output logic                           key_pressed,
  output logic                           enter_pressed,
  output logic                           bksp_pressed,
  output logic [CHAR_W-1:0]              character,
  output logic                           line_valid,
  input  logic                           line_ready,
  output logic [$clog2(MAX_LEN+1)-1:0]   line_len,
  output logic [8*MAX_LEN-1:0]           line_data,
  output logic                           frame_err,
  output logic                           overflow
);

  localparam int LW = $clog2(MAX_LEN + 1);

  logic                 byte_valid;
  logic                 rx_err;
  logic [7:0]           rx_byte;
  logic                 brk;
  logic                 ext;
  logic                 shift;
  logic [8:0]           lookup;
  logic [7:0]           ascii;
  logic                 key_evt;
  logic [LW-1:0]        wp;
  logic [8*MAX_LEN-1:0] edit_buf;

  ps2_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .byte_valid (byte_valid),
    .data_byte  (rx_byte),
    .err        (rx_err)
  );

  assign lookup  = sc_to_ascii(rx_byte, shift);
  assign ascii   = lookup[7:0];
  assign key_evt = byte_valid && lookup[8] && !brk && !ext;

`ifdef PS2_SHIFT_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) shift <= 1'b0;
    else if (byte_valid && !ext && (rx_byte == SC_LSHIFT || rx_byte == SC_RSHIFT))
      shift <= !brk;
  end
`else
  assign shift = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      key_pressed   <= 1'b0;
      enter_pressed <= 1'b0;
      bksp_pressed  <= 1'b0;
      overflow      <= 1'b0;
      frame_err     <= 1'b0;
      character     <= '0;
      line_valid    <= 1'b0;
      line_len      <= '0;
      line_data     <= '0;
      wp            <= '0;
      edit_buf      <= '0;
      brk           <= 1'b0;
      ext           <= 1'b0;
    end else begin
      key_pressed   <= 1'b0;
      enter_pressed <= 1'b0;
      bksp_pressed  <= 1'b0;
      overflow      <= 1'b0;
      frame_err     <= rx_err;
      if (line_valid && line_ready) line_valid <= 1'b0;

      // Prefix bytes arm a flag; any other byte consumes and clears both.
      if (byte_valid) begin
        if (rx_byte == SC_BREAK)    brk <= 1'b1;
        else if (rx_byte == SC_EXT) ext <= 1'b1;
        else begin
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end

      if (key_evt) begin
        if (line_valid) begin
          overflow <= 1'b1;
        end else if (ascii == ASCII_ENTER) begin
          line_data     <= edit_buf;
          line_len      <= wp;
          line_valid    <= 1'b1;
          enter_pressed <= 1'b1;
          wp            <= '0;
          edit_buf      <= '0;
        end else if (ascii == ASCII_BKSP) begin
          if (wp != '0) begin
            wp <= wp - LW'(1);
            edit_buf[8*(int'(wp)-1) +: 8] <= 8'h00;
            bksp_pressed <= 1'b1;
          end
        end else if (int'(wp) < MAX_LEN) begin
          edit_buf[8*int'(wp) +: 8] <= ascii;
          wp          <= wp + LW'(1);
          key_pressed <= 1'b1;
          character   <= CHAR_W'(ascii);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_line_buffer.sv
// tb/tb_ps2_line_buffer.sv - self-checking bench for ps2_line_buffer (table vectors, directed corners, random model)
module tb_ps2_line_buffer;

  localparam int ML   = 4;
  localparam int SS   = 2;
  localparam int TO   = 200;
  localparam int H    = 6;
  localparam int LW   = $clog2(ML + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ps2_clk = 1'b1;
  logic              ps2_data = 1'b1;
  logic              line_ready = 1'b0;
  logic              key_pressed, enter_pressed, bksp_pressed, line_valid, frame_err, overflow;
  logic [15:0]       character;
  logic [LW-1:0]     line_len;
  logic [8*ML-1:0]   line_data;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    stop_cyc = 0;
  int    last_lat = 0;
  string got = "";

  typedef struct {
    int          nb;
    logic [63:0] b;
    string       kinds;
    logic [7:0]  ch;
    int          len;
    logic [31:0] data;
  } vec_t;
  vec_t vecs[$];

  logic [7:0] kcode [39] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                             8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                             8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h45, 8'h16, 8'h1E, 8'h26,
                             8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h29, 8'h41, 8'h49};
  string kchars = "abcdefghijklmnopqrstuvwxyz0123456789 ,.";

  logic [7:0]  mq[$];
  int          mlen = 0;
  logic [31:0] mdata = '0;
  bit          mvalid = 1'b0;
  logic [7:0]  mchar = '0;

  ps2_line_buffer #(.MAX_LEN(ML), .CHAR_W(16), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk), .rst_in(rst), .ps2_clk_in(ps2_clk), .ps2_data_in(ps2_data),
    .key_pressed(key_pressed), .enter_pressed(enter_pressed), .bksp_pressed(bksp_pressed),
    .character(character), .line_valid(line_valid), .line_ready(line_ready),
    .line_len(line_len), .line_data(line_data), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (key_pressed | enter_pressed | bksp_pressed | overflow | frame_err) begin
      n_tests++;
      if ($countones({key_pressed, enter_pressed, bksp_pressed, overflow, frame_err}) != 1) begin
        n_fail++;
        $display("FAIL pulse_exclusive: got %b required one-hot", {key_pressed, enter_pressed, bksp_pressed, overflow, frame_err});
      end
      if (key_pressed)   got = {got, "K"};
      if (enter_pressed) got = {got, "E"};
      if (bksp_pressed)  got = {got, "B"};
      if (overflow)      got = {got, "O"};
      if (frame_err)     got = {got, "F"};
      last_lat = cyc - stop_cyc;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_s(input string name, input string act, input string exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got '%s' required '%s'", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, ~(^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk  = 1'b0;
      stop_cyc = cyc;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    send_frame(frame(b, bad_par), 11);
  endtask

  task automatic accept_line();
    check("hs_valid_before", 64'(line_valid), 64'd1);
    @(negedge clk);
    line_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_valid_clear", 64'(line_valid), 64'd0);
    @(negedge clk);
    line_ready = 1'b0;
  endtask

  task automatic add_vec(input int nb, input logic [63:0] b, input string kinds,
                         input logic [7:0] ch, input int len, input logic [31:0] data);
    vec_t v;
    v.nb = nb; v.b = b; v.kinds = kinds; v.ch = ch; v.len = len; v.data = data;
    vecs.push_back(v);
  endtask

  initial begin
    add_vec(5, 64'h00_00_00_5A_32_1C_F0_1C, "KKE",     8'h62, 2, 32'h0000_6261);
    add_vec(6, 64'h00_00_5A_66_66_66_32_1C, "KKBBE",   8'h62, 0, 32'h0000_0000);
    add_vec(7, 64'h00_5A_22_22_22_22_22_22, "KKKKOOE", 8'h78, 4, 32'h7878_7878);
    add_vec(6, 64'h00_00_5A_75_F0_E0_75_E0, "E",       8'h78, 0, 32'h0000_0000);
    add_vec(6, 64'h00_00_5A_29_41_49_16_45, "KKKKOE",  8'h2C, 4, 32'h2C2E_3130);
`ifdef PS2_SHIFT_EN
    add_vec(6, 64'h00_00_5A_12_F0_1C_76_12, "KE",      8'h41, 1, 32'h0000_0041);
    add_vec(7, 64'h00_5A_16_59_F0_41_16_59, "KKKE",    8'h31, 3, 32'h0031_3C21);
`else
    add_vec(6, 64'h00_00_5A_12_F0_1C_76_12, "KE",      8'h61, 1, 32'h0000_0061);
    add_vec(7, 64'h00_5A_16_59_F0_41_16_59, "KKKE",    8'h31, 3, 32'h0031_2C31);
`endif

    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({key_pressed, enter_pressed, bksp_pressed, character, line_valid,
                                line_len, line_data, frame_err, overflow}), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    foreach (vecs[i]) begin
      got = "";
      for (int j = 0; j < vecs[i].nb; j++) send_byte(vecs[i].b[8*j +: 8], 1'b0);
      check_s($sformatf("vec%0d_events", i), got, vecs[i].kinds);
      check($sformatf("vec%0d_char", i), 64'(character), 64'(vecs[i].ch));
      check($sformatf("vec%0d_len", i), 64'(line_len), 64'(vecs[i].len));
      check($sformatf("vec%0d_data", i), 64'(line_data), 64'(vecs[i].data));
      accept_line();
    end

    // Key while a line is pending is dropped and the held line stays intact.
    send_byte(8'h1C, 1'b0);
    send_byte(8'h5A, 1'b0);
    got = "";
    send_byte(8'h32, 1'b0);
    check_s("hold_overflow", got, "O");
    check("hold_len", 64'(line_len), 64'd1);
    check("hold_data", 64'(line_data), 64'h61);
    accept_line();

    got = "";
    send_byte(8'h32, 1'b0);
    check_s("latency_event", got, "K");
    check("latency_cycles", 64'(last_lat), 64'(SS + 2));
    send_byte(8'h5A, 1'b0);
    accept_line();

    got = "";
    send_byte(8'h1C, 1'b1);
    check_s("parity_err", got, "F");
    check("parity_err_lat", 64'(last_lat), 64'(SS + 2));
    got = "";
    send_frame({1'b0, ~(^8'h1C), 8'h1C, 1'b0}, 11);
    check_s("stop_err", got, "F");
    got = "";
    send_frame(11'h7FF, 1);
    check_s("start_err", got, "F");
    check("start_err_lat", 64'(last_lat), 64'(SS + 2));

    send_frame(frame(8'h1C, 1'b0), 5);
    got = "";
    repeat (100) @(negedge clk);
    check_s("timeout_early", got, "");
    for (int t = 0; t < 300 && got == ""; t++) @(negedge clk);
    check_s("timeout_err", got, "F");
    got = "";
    send_byte(8'h1C, 1'b0);
    send_byte(8'h5A, 1'b0);
    check_s("after_timeout", got, "KE");
    check("after_timeout_len", 64'(line_len), 64'd1);
    check("after_timeout_data", 64'(line_data), 64'h61);

    // Asynchronous reset in the middle of a frame, with a line still pending.
    send_frame(frame(8'h32, 1'b0), 5);
    #2 rst = 1'b1;
    #1;
    check("async_reset", 64'({key_pressed, enter_pressed, bksp_pressed, character, line_valid,
                              line_len, line_data, frame_err, overflow}), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    got = "";
    repeat (TO + 50) @(negedge clk);
    check_s("reset_no_spurious", got, "");
    send_byte(8'h1C, 1'b0);
    send_byte(8'h5A, 1'b0);
    check_s("post_reset_events", got, "KE");
    check("post_reset_data", 64'(line_data), 64'h61);
    accept_line();
    mchar = 8'h61;

    for (int a = 0; a < 60; a++) begin
      int r;
      int k;
      string exp_k;
      logic [7:0] c;
      r = $urandom_range(0, 99);
      k = $urandom_range(0, 38);
      c = kchars[k];
      exp_k = "";
      if (mvalid && $urandom_range(0, 2) == 0) begin
        check("rand_len", 64'(line_len), 64'(mlen));
        check("rand_data", 64'(line_data), 64'(mdata));
        accept_line();
        mvalid = 1'b0;
      end
      got = "";
      if (r < 55) begin
        send_byte(kcode[k], 1'b0);
        if (mvalid) exp_k = "O";
        else if (mq.size() < ML) begin
          mq.push_back(c);
          mchar = c;
          exp_k = "K";
        end else exp_k = "O";
      end else if (r < 65) begin
        send_byte(8'h66, 1'b0);
        if (mvalid) exp_k = "O";
        else if (mq.size() > 0) begin
          void'(mq.pop_back());
          exp_k = "B";
        end
      end else if (r < 72) begin
        send_byte(8'h5A, 1'b0);
        if (mvalid) exp_k = "O";
        else begin
          mdata = '0;
          foreach (mq[i]) mdata[8*i +: 8] = mq[i];
          mlen = mq.size();
          mq.delete();
          mvalid = 1'b1;
          exp_k = "E";
        end
      end else if (r < 82) begin
        send_byte(8'hF0, 1'b0);
        send_byte(kcode[k], 1'b0);
      end else if (r < 88) begin
        send_byte(8'hE0, 1'b0);
        send_byte(kcode[k], 1'b0);
      end else if (r < 94) begin
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(kcode[k], 1'b0);
      end else begin
        send_byte(8'h76, 1'b0);
      end
      check_s($sformatf("rand%0d_event", a), got, exp_k);
      check($sformatf("rand%0d_char", a), 64'(character), 64'(mchar));
      check($sformatf("rand%0d_valid", a), 64'(line_valid), 64'(mvalid));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_line_buffer.md
# ps2_line_buffer

Parametrised PS/2 keyboard front end that deserializes 11-bit PS/2 frames, decodes make/break scancodes to ASCII and assembles typed characters into a bounded line buffer with backspace editing. A completed line is held on a valid/ready handshake for the instruction parser, and per-key event pulses continue to feed the on-screen text display. It sits between the PS/2 pins and the parser/display logic, all in the `clk_in` domain.

## Interface
- `MAX_LEN`, 32: line capacity in characters (≥2).
- `CHAR_W`, 16: width of the `character` output (≥8). ASCII is zero-extended to this width.
- `SYNC_STAGES`, 2: synchronizer depth on `ps2_clk_in` and `ps2_data_in` (≥2).
- `TIMEOUT_CYCLES`, 20000: `clk_in` cycles without a PS/2 falling edge before a partial frame is abandoned.
- `clk_in` input 1: system clock, single domain.
- `rst_in` input 1: reset, asynchronous, active-high.
- `ps2_clk_in` input 1: raw PS/2 clock, asynchronous.
- `ps2_data_in` input 1: raw PS/2 data, asynchronous.
- `key_pressed` output 1: 1-cycle pulse, printable character appended.
- `enter_pressed` output 1: 1-cycle pulse, line committed.
- `bksp_pressed` output 1: 1-cycle pulse, character removed.
- `character` output CHAR_W: ASCII of last appended char, held until the next append.
- `line_valid` output 1: committed line available.
- `line_ready` input 1: consumer accepts the line.
- `line_len` output $clog2(MAX_LEN+1): number of chars in the committed line.
- `line_data` output 8*MAX_LEN: committed chars, char i at bits [8i+7:8i], unused slots 0.
- `frame_err` output 1: 1-cycle pulse on parity, start, stop or timeout error.
- `overflow` output 1: 1-cycle pulse when a key is dropped.

## Operation
- Receiver: synchronize both inputs, detect falling edge of synced PS/2 clock, sample data on it. Frame = start(0), 8 data LSB-first, odd parity, stop(1). States IDLE, DATA, PARITY, STOP. Bad start, parity or stop → `frame_err`, byte discarded, return to IDLE.
- Timeout: in DATA/PARITY/STOP, TIMEOUT_CYCLES cycles with no falling edge → `frame_err`, IDLE. Counter clears on every edge.
- Decoder: `F0` arms break, next byte is a release (no event). `E0` arms extended, next byte (make or break) ignored. Make of a mapped code yields an event. Unmapped makes are ignored silently.
- Map: letters a–z, digits 0–9, `0x41`→',', `0x49`→'.', `0x29`→' ', `0x5A`→enter, `0x66`→backspace. Typematic repeats produce repeated events.
- Edit buffer: write pointer `wp`, 0..MAX_LEN.
  - Printable with wp<MAX_LEN: store, wp+1, `key_pressed`, update `character`.
  - Printable with wp==MAX_LEN: dropped, `overflow`.
  - Backspace with wp>0: wp−1, slot cleared, `bksp_pressed`. With wp==0: no-op, no pulse.
  - Enter: copy buffer to `line_data`, `line_len`=wp, set `line_valid`, wp=0, `enter_pressed`. An empty line is legal.
- Handshake: `line_valid` holds and `line_data`/`line_len` stay stable until the cycle `line_valid && line_ready`; it clears the next cycle.
  - Every key event while `line_valid` is high is dropped with `overflow`, so no edit to the next line occurs.
  - `line_ready` while `line_valid` is low is ignored.
- Reset: all outputs 0, `line_data` 0, wp 0, receiver IDLE, break/extended/shift flags clear. Reset mid-frame discards the partial frame, with no pulse after release.

## Timing
- Event pulses (`key_pressed`, `enter_pressed`, `bksp_pressed`, `overflow`) assert exactly SYNC_STAGES+2 `clk_in` cycles after the stop-bit falling edge appears on `ps2_clk_in`.
- `frame_err` timing: parity and stop errors at the same latency. Start error at the same latency after the start-bit edge. Timeout errors assert on the expiry cycle.
- `line_valid` rises in the same cycle as `enter_pressed`.
- At most one event per cycle, so events are mutually exclusive.
- Minimum PS/2 clock half-period supported: SYNC_STAGES+2 `clk_in` cycles.

## Configuration
- `PS2_SHIFT_EN` defined:
  - Make of `0x12`/`0x59` sets shift; break of either clears it.
  - Letters map to uppercase while shift is held.
  - Shifted digits map to US symbols (e.g. shift+1 → '!'), shifted ',' → '<', shifted '.' → '>'.
- Undefined: shift codes are treated as unmapped and output is lowercase only.

## Structure
- `ps2_pkg`:
  - Scancode constants (`SC_BREAK`=F0, `SC_EXT`=E0, `SC_ENTER`, `SC_BKSP`, `SC_LSHIFT`, `SC_RSHIFT`).
  - Receiver state enum.
  - Pure function `sc_to_ascii(code, shift)` returning {valid, ascii}.
- Sub-module `ps2_rx`: synchronizer, edge detect, frame FSM and timeout. It outputs `byte_valid` pulse, `byte`, `err`.
- The top level holds the decoder, edit buffer and handshake.

## Test plan
- Frames 1C, F0 1C, 32, 5A with `line_ready`=0 → two `key_pressed` ('a'=0x61, 'b'=0x62), `enter_pressed`, `line_valid`=1, `line_len`=2, `line_data[15:0]`=0x6261. Then `line_ready`=1 for 1 cycle → `line_valid` 0 next cycle.
- 'a','b',bksp,bksp,bksp,enter → two `bksp_pressed` only (third no pulse), `line_len`=0.
- MAX_LEN=4, six 'x' (0x22) then enter → 4 `key_pressed`, 2 `overflow`, `line_len`=4. Another key while `line_valid` high → `overflow`.
- Frame 1C with wrong parity → `frame_err`, no event. Frame stopped after 4 data bits → `frame_err` after TIMEOUT_CYCLES, and the next good frame decodes correctly.
- E0 75, E0 F0 75 (arrow) → no events. With `PS2_SHIFT_EN`: 12, 1C, F0 12, 1C → characters 'A' (0x41), then 'a'.
- `rst_in` pulsed asynchronously mid-frame → outputs 0 immediately, and the following clean frame decodes with no spurious pulse.
